max_pool_2x2: RTL and testbench

//   Streaming 2x2 / stride-2 max-pooling stage placed directly downstream of

---
 rtl/max_pool_2x2.sv | 87 ++++++++
 tb/tb_max_pool_2x2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_2x2
// Purpose  : Streaming 2x2 / stride-2 unsigned max-pool over a raster pixel stream.
// Revision : 1.0  initial release
// ============================================================================
module max_pool_2x2 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inValid,
  input  logic                 sof,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 valid
);

  localparam int c_HALF = (ROW_SIZE / 2 > 0) ? ROW_SIZE / 2 : 1;
  localparam int c_CW   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int c_AW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;

  logic [c_CW-1:0]      r_col;
  logic                 r_row_odd;
  logic [WORD_SIZE-1:0] r_pair_max;
  logic [WORD_SIZE-1:0] r_out_pixel;
  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_line_buf [c_HALF];

  logic [c_CW-1:0]      w_col;
  logic [c_CW-1:0]      w_col_nxt;
  logic                 w_row_odd;
  logic                 w_row_odd_nxt;
  logic                 w_last_col;
  logic [c_AW-1:0]      w_lb_idx;
  logic [WORD_SIZE-1:0] w_h;
  logic [WORD_SIZE-1:0] w_lb_rd;
  logic [WORD_SIZE-1:0] w_win_max;

  // sof forces the current pixel to be treated as col 0 of an even row
  always_comb begin
    w_col         = sof ? '0 : r_col;
    w_row_odd     = sof ? 1'b0 : r_row_odd;
    w_last_col    = (w_col == c_CW'(ROW_SIZE - 1));
    w_col_nxt     = w_last_col ? '0 : w_col + c_CW'(1);
    w_row_odd_nxt = w_last_col ? ~w_row_odd : w_row_odd;
    w_lb_idx      = c_AW'(w_col >> 1);
    w_h           = (inputPixel > r_pair_max) ? inputPixel : r_pair_max;
    w_lb_rd       = r_line_buf[w_lb_idx];
    w_win_max     = (w_lb_rd > w_h) ? w_lb_rd : w_h;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_row_odd   <= 1'b0;
      r_pair_max  <= '0;
      r_out_pixel <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (inValid) begin
        r_col     <= w_col_nxt;
        r_row_odd <= w_row_odd_nxt;
        if (!w_col[0]) begin
          r_pair_max <= inputPixel;
        end else if (w_row_odd) begin
          r_out_pixel <= w_win_max;
          r_valid     <= 1'b1;
        end
      end
    end
  end

  // Line buffer is never reset: each entry is written on an even row before use
  always_ff @(posedge clk) begin
    if (inValid && w_col[0] && !w_row_odd) begin
      r_line_buf[w_lb_idx] <= w_h;
    end
  end

  assign outputPixel = r_out_pixel;
  assign valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_2x2
// Purpose  : Directed self-checking bench for max_pool_2x2 with ROW_SIZE=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_max_pool_2x2;

  logic       clk;
  logic       rst;
  logic [7:0] inputPixel;
  logic       inValid;
  logic       sof;
  logic [7:0] outputPixel;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  max_pool_2x2 #(
    .WORD_SIZE(8),
    .ROW_SIZE (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inputPixel (inputPixel),
    .inValid    (inValid),
    .sof        (sof),
    .outputPixel(outputPixel),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // One accepted pixel; sampled just after the accepting edge
  task automatic send(input string tag, input logic [7:0] px, input logic s,
                      input logic ev, input logic [7:0] ep);
    @(negedge clk);
    inputPixel = px;
    inValid    = 1'b1;
    sof        = s;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {7'd0, valid}, {7'd0, ev});
    if (ev) chk({tag, "_pixel"}, outputPixel, ep);
    inValid = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inValid    = 1'b0;
      sof        = 1'b1;
      inputPixel = 8'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_idle_valid"}, {7'd0, valid}, 8'd0);
      sof = 1'b0;
    end
  endtask

  // Row pixels packed MSB-first; e1/e3 are the outputs expected on odd rows
  task automatic row(input string tag, input logic [31:0] px, input logic odd,
                     input logic [7:0] e1, input logic [7:0] e3,
                     input int gap, input logic first_sof);
    send(tag, px[31:24], first_sof, 1'b0, 8'h00);
    idle(tag, gap);
    send(tag, px[23:16], 1'b0, odd, e1);
    idle(tag, gap);
    send(tag, px[15:8], 1'b0, 1'b0, 8'h00);
    idle(tag, gap);
    send(tag, px[7:0], 1'b0, odd, e3);
    idle(tag, gap);
  endtask

  initial begin
    rst        = 1'b0;
    inValid    = 1'b0;
    sof        = 1'b0;
    inputPixel = 8'h00;

    // Held in reset with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      inputPixel = 8'($urandom);
      inValid    = 1'($urandom);
      sof        = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_valid", {7'd0, valid}, 8'd0);
      chk("rst_pixel", outputPixel, 8'h00);
    end
    @(negedge clk);
    inValid = 1'b0;
    sof     = 1'b0;
    rst     = 1'b1;

    // Continuous stream
    row("t2r0", 32'h01020304, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    row("t2r1", 32'h05060708, 1'b1, 8'h06, 8'h08, 0, 1'b0);

    // Same data with 3 idle cycles between pixels
    row("t3r0", 32'h01020304, 1'b0, 8'h00, 8'h00, 3, 1'b0);
    row("t3r1", 32'h05060708, 1'b1, 8'h06, 8'h08, 3, 1'b0);
    chk("t3_hold", outputPixel, 8'h08);

    // Garbage then sof realigns the frame
    send("t4g", 8'hEE, 1'b0, 1'b0, 8'h00);
    send("t4g", 8'hFD, 1'b0, 1'b0, 8'h00);
    row("t4r0", 32'h10203040, 1'b0, 8'h00, 8'h00, 0, 1'b1);
    row("t4r1", 32'h50607080, 1'b1, 8'h60, 8'h80, 0, 1'b0);

    // Unsigned compare
    row("t5r0", 32'h7FFF0080, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    row("t5r1", 32'h807F0100, 1'b1, 8'hFF, 8'h80, 0, 1'b0);

    // Reset after row 1 col 1
    row("t6r0", 32'hAAAAAAAA, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    send("t6a", 8'hBB, 1'b0, 1'b0, 8'h00);
    send("t6a", 8'hBB, 1'b0, 1'b1, 8'hBB);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", {7'd0, valid}, 8'd0);
    chk("t6_async_pixel", outputPixel, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    row("t6r0b", 32'h09090909, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    row("t6r1b", 32'h01010101, 1'b1, 8'h09, 8'h09, 0, 1'b0);
    idle("t6_tail", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d expected=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
